// File: rtl/color_stream_engine_if.sv
// MIG user-port bundle: one command channel plus read and write data FIFOs.
interface color_stream_engine_if #(
  parameter int unsigned ADDR_W = 30
);
  logic [31:0]       rd_data;
  logic [6:0]        rd_count;
  logic              rd_empty;
  logic              rd_en;
  logic [6:0]        wr_count;
  logic [31:0]       wr_data;
  logic              wr_en;
  logic [2:0]        cmd_instr;
  logic [5:0]        cmd_bl;
  logic [ADDR_W-1:0] cmd_byte_addr;
  logic              cmd_en;

  modport master (
    input  rd_data, rd_count, rd_empty, wr_count,
    output rd_en, wr_data, wr_en, cmd_instr, cmd_bl, cmd_byte_addr, cmd_en
  );

  modport slave (
    output rd_data, rd_count, rd_empty, wr_count,
    input  rd_en, wr_data, wr_en, cmd_instr, cmd_bl, cmd_byte_addr, cmd_en
  );
endinterface

// File: rtl/color_stream_engine.sv
// Streams iteration counts from DRAM through an external palette and writes
// packed RGB words back to the framebuffer in bursts, with per-frame colour cycling.
module color_stream_engine #(
  parameter int unsigned BURST_MAX  = 64,
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned PIX_W      = 21,
  parameter int unsigned READ_BASE  = 0,
  parameter int unsigned WRITE_BASE = 5242880,
  parameter int unsigned LUT_LAT    = 1,
  parameter int unsigned OFS_STEP   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [PIX_W-1:0]      total_pixels,
  input  logic                  mem_calib_done,
  color_stream_engine_if.master mem,
  output logic [31:0]           lut_iter,
  output logic [31:0]           lut_offset,
  input  logic [23:0]           lut_color,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CAL      = 4'd1,
    S_RD_CMD   = 4'd2,
    S_RD_WAIT  = 4'd3,
    S_XFER     = 4'd4,
    S_FLUSH    = 4'd5,
    S_WR_CMD   = 4'd6,
    S_WR_DRAIN = 4'd7,
    S_NEXT     = 4'd8
  } state_t;

  state_t cur_state, next_state;

  logic [1:0]         calib_sync;
  logic [PIX_W-1:0]   total_r, pix, amount, rd_left;
  logic [PIX_W-1:0]   remain, burst_amt, pix_next;
  logic [LUT_LAT-1:0] vpipe;
  logic               rd_en_q, accept, frame_end;
  logic               cmd_en_q;
  logic [2:0]         cmd_instr_q;
  logic [5:0]         cmd_bl_q;
  logic [ADDR_W-1:0]  cmd_addr_q;

  assign remain    = total_r - pix;
  assign burst_amt = (remain > PIX_W'(BURST_MAX)) ? PIX_W'(BURST_MAX) : remain;
  assign pix_next  = pix + amount;
  assign accept    = (cur_state == S_IDLE) && start && !busy;
  assign frame_end = (cur_state == S_NEXT) && !(pix_next < total_r);

  assign state             = cur_state;
  assign mem.rd_en         = rd_en_q;
  assign mem.wr_en         = vpipe[LUT_LAT-1];
  assign mem.cmd_en        = cmd_en_q;
  assign mem.cmd_instr     = cmd_instr_q;
  assign mem.cmd_bl        = cmd_bl_q;
  assign mem.cmd_byte_addr = cmd_addr_q;
  // Gating on the strobes keeps these outputs at zero whenever reset is held.
  assign lut_iter          = rd_en_q ? mem.rd_data : '0;
  assign mem.wr_data       = vpipe[LUT_LAT-1] ? {8'h00, lut_color} : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur_state <= S_IDLE;
    else          cur_state <= next_state;
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_IDLE:     if (accept && total_pixels != '0) next_state = S_CAL;
      S_CAL:      if (calib_sync[1]) next_state = (total_r == '0) ? S_NEXT : S_RD_CMD;
      S_RD_CMD:   if (mem.rd_empty) next_state = S_RD_WAIT;
      S_RD_WAIT:  if (PIX_W'(mem.rd_count) == amount) next_state = S_XFER;
      S_XFER:     if (rd_left == '0) next_state = S_FLUSH;
      S_FLUSH:    if (vpipe == '0) next_state = S_WR_CMD;
      S_WR_CMD:   next_state = S_WR_DRAIN;
      S_WR_DRAIN: if (mem.wr_count == '0) next_state = S_NEXT;
      S_NEXT: begin
        if (pix_next < total_r) next_state = S_RD_CMD;
        else if (continuous)    next_state = S_CAL;
        else                    next_state = S_IDLE;
      end
      default:    next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      calib_sync  <= '0;
      total_r     <= '0;
      pix         <= '0;
      amount      <= '0;
      rd_left     <= '0;
      rd_en_q     <= 1'b0;
      vpipe       <= '0;
      cmd_en_q    <= 1'b0;
      cmd_instr_q <= '0;
      cmd_bl_q    <= '0;
      cmd_addr_q  <= '0;
      lut_offset  <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      calib_sync <= {calib_sync[0], mem_calib_done};
      cmd_en_q   <= 1'b0;
      frame_done <= 1'b0;
      // wr_en is the tail of this pipe, so it lines up with lut_color.
      vpipe[0] <= rd_en_q;
      for (int unsigned i = 1; i < LUT_LAT; i++) vpipe[i] <= vpipe[i-1];

      if (accept) begin
        busy    <= 1'b1;
        total_r <= total_pixels;
        pix     <= '0;
        amount  <= '0;
        if (total_pixels == '0) begin
          frame_done  <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end
      end else if (frame_done && cur_state == S_IDLE) begin
        busy <= 1'b0;
      end

      case (cur_state)
        S_RD_CMD: if (mem.rd_empty) begin
          cmd_en_q    <= 1'b1;
          cmd_instr_q <= 3'b001;
          cmd_bl_q    <= 6'(burst_amt - PIX_W'(1));
          cmd_addr_q  <= ADDR_W'(READ_BASE) + (ADDR_W'(pix) << 2);
          amount      <= burst_amt;
        end
        S_RD_WAIT: if (next_state == S_XFER) begin
          rd_en_q <= 1'b1;
          rd_left <= amount - PIX_W'(1);
        end
        S_XFER: begin
          if (rd_left == '0) rd_en_q <= 1'b0;
          else               rd_left <= rd_left - PIX_W'(1);
        end
        S_WR_CMD: begin
          cmd_en_q    <= 1'b1;
          cmd_instr_q <= 3'b000;
          cmd_bl_q    <= 6'(amount - PIX_W'(1));
          cmd_addr_q  <= ADDR_W'(WRITE_BASE) + (ADDR_W'(pix) << 2);
        end
        S_NEXT: begin
          if (!frame_end) begin
            pix <= pix_next;
          end else begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            if (continuous) begin
              lut_offset <= lut_offset + 32'(OFS_STEP);
              total_r    <= total_pixels;
              pix        <= '0;
              amount     <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
